uart_mem_loader: RTL and testbench

- Downstream consumer of the UART byte receiver.
- Packs received bytes into 32-bit little-endian words and writes them sequentially into instruction/data memory through a single-cycle write port.
- Uses the receiver's timeout flag as the end-of-image marker. Signals load completion to the CPU boot/reset controller.

---
 rtl/uart_mem_loader_pkg.sv | 28 ++
 rtl/uart_mem_loader_edge_detect.sv | 21 ++
 rtl/uart_mem_loader.sv | 165 ++++++++++++++++
 tb/tb_uart_mem_loader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the UART memory loader: FSM encoding, word geometry
// and the little-endian byte-lane placement helper.
package uart_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int LANE_BITS  = 8;

    // Lane k sits at bits [8k+7:8k], so the first byte received lands in the LSBs.
    localparam int LANE0_LSB  = 0;

    function automatic logic [31:0] place_byte(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        w[LANE0_LSB + int'(lane) * LANE_BITS +: LANE_BITS] = b;
        return w;
    endfunction

endpackage

// File: rtl/uart_mem_loader_edge_detect.sv
// One-flop rising-edge detector; turns a held level into a single-cycle strobe.
module uart_mem_loader_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_dly;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dly <= 1'b0;
        end else begin
            r_dly <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_dly;

endmodule

// File: rtl/uart_mem_loader.sv
// Packs UART bytes into little-endian 32-bit words, writes them to memory and
// flags completion when the receiver's idle timeout rises.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_data,
    input  logic                  i_valid,
    input  logic                  i_clear_sign,
    input  logic                  i_rearm,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_data,
    output logic                  o_mem_we,
    output logic                  o_busy,
    output logic                  o_load_done,
    output logic                  o_overflow,
    output logic [ADDR_WIDTH:0]   o_word_count
);

    localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   MAX_CNT = (ADDR_WIDTH + 1)'(MAX_WORDS);

    logic        w_byte_strobe;
    logic        w_end_strobe;
    logic        w_accept;
    logic        w_dropped;
    logic        w_word_done;
    logic        w_end;
    logic [1:0]  w_cnt_next;
    logic [31:0] w_packed;

    state_t      r_state;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_buf;
    logic        r_end_pending;

    uart_mem_loader_edge_detect u_valid_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sig   (i_valid),
        .o_rise  (w_byte_strobe)
    );

    uart_mem_loader_edge_detect u_clear_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sig   (i_clear_sign),
        .o_rise  (w_end_strobe)
    );

    assign w_accept    = w_byte_strobe && (o_word_count != MAX_CNT);
    assign w_dropped   = w_byte_strobe && (o_word_count == MAX_CNT);
    assign w_cnt_next  = r_byte_cnt + 2'(w_accept);
    assign w_word_done = w_accept && (r_byte_cnt == 2'(WORD_BYTES - 1));
    assign w_packed    = w_accept ? place_byte(r_buf, r_byte_cnt, i_data) : r_buf;
    // An end seen during WRITE is carried into the following COLLECT cycle.
    assign w_end       = w_end_strobe | r_end_pending;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_byte_cnt    <= 2'd0;
            r_buf         <= 32'd0;
            r_end_pending <= 1'b0;
            o_mem_addr    <= BASE;
            o_mem_data    <= 32'd0;
            o_mem_we      <= 1'b0;
            o_busy        <= 1'b0;
            o_load_done   <= 1'b0;
            o_overflow    <= 1'b0;
            o_word_count  <= '0;
        end else begin
            // The address and count advance on the edge that ends each write strobe.
            if (o_mem_we) begin
                o_mem_we     <= 1'b0;
                o_mem_addr   <= o_mem_addr + ADDR_WIDTH'(1);
                o_word_count <= o_word_count + (ADDR_WIDTH + 1)'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_buf      <= w_packed;
                        r_byte_cnt <= w_cnt_next;
                        o_busy     <= 1'b1;
                        r_state    <= ST_COLLECT;
                    end
                end

                ST_COLLECT: begin
                    r_buf         <= w_packed;
                    r_byte_cnt    <= w_cnt_next;
                    r_end_pending <= 1'b0;
                    if (w_dropped) begin
                        o_overflow <= 1'b1;
                    end
                    if (w_word_done) begin
                        r_end_pending <= w_end;
                        r_state       <= ST_WRITE;
                    end else if (w_end) begin
                        if (w_cnt_next != 2'd0) begin
                            r_state <= ST_FLUSH;
                        end else begin
                            o_load_done <= 1'b1;
                            o_busy      <= 1'b0;
                            r_state     <= ST_DONE;
                        end
                    end
                end

                ST_WRITE: begin
                    o_mem_we   <= 1'b1;
                    o_mem_data <= r_buf;
                    r_buf      <= w_accept ? place_byte(32'd0, r_byte_cnt, i_data) : 32'd0;
                    r_byte_cnt <= w_cnt_next;
                    if (w_dropped) begin
                        o_overflow <= 1'b1;
                    end
                    if (r_end_pending) begin
                        r_end_pending <= 1'b0;
                        o_load_done   <= 1'b1;
                        o_busy        <= 1'b0;
                        r_state       <= ST_DONE;
                    end else begin
                        r_end_pending <= w_end_strobe;
                        r_state       <= ST_COLLECT;
                    end
                end

                ST_FLUSH: begin
                    o_mem_we    <= 1'b1;
                    o_mem_data  <= r_buf;
                    r_buf       <= 32'd0;
                    r_byte_cnt  <= 2'd0;
                    o_load_done <= 1'b1;
                    o_busy      <= 1'b0;
                    r_state     <= ST_DONE;
                end

                ST_DONE: begin
                    if (i_rearm) begin
                        o_load_done   <= 1'b0;
                        o_overflow    <= 1'b0;
                        o_mem_addr    <= BASE;
                        o_word_count  <= '0;
                        r_buf         <= 32'd0;
                        r_byte_cnt    <= 2'd0;
                        r_end_pending <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: table-driven images plus hand-built
// corner sequences, with memory writes checked against a scoreboard queue.
module tb_uart_mem_loader;

    localparam int AW   = 8;
    localparam int HOLD = 40;
    localparam int GAP  = 10;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [63:0] bytesLe;
        logic [3:0]  nBytes;
        logic [8:0]  expCount;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstN;
    logic          validIn;
    logic          clearSign;
    logic          rearm;
    logic [7:0]    dataIn;

    logic [AW-1:0] addrMain,  addrSmall;
    logic [31:0]   dataMain,  dataSmall;
    logic          weMain,    weSmall;
    logic          busyMain,  busySmall;
    logic          doneMain,  doneSmall;
    logic          ovfMain,   ovfSmall;
    logic [AW:0]   cntMain,   cntSmall;

    int            checkCount = 0;
    int            passCount  = 0;

    wr_t           expQ[$];
    wr_t           expQSmall[$];
    logic [31:0]   modelWord;
    int            modelLane;
    logic [7:0]    expAddr;
    logic [7:0]    smallAddr;
    int            smallWords;
    bit            smallActive = 1'b0;

    vec_t          vecs[4];

    always #5 clk = ~clk;

    uart_mem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .MAX_WORDS(256)) dutMain (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_data       (dataIn),
        .i_valid      (validIn),
        .i_clear_sign (clearSign),
        .i_rearm      (rearm),
        .o_mem_addr   (addrMain),
        .o_mem_data   (dataMain),
        .o_mem_we     (weMain),
        .o_busy       (busyMain),
        .o_load_done  (doneMain),
        .o_overflow   (ovfMain),
        .o_word_count (cntMain)
    );

    uart_mem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .MAX_WORDS(2)) dutSmall (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_data       (dataIn),
        .i_valid      (validIn),
        .i_clear_sign (clearSign),
        .i_rearm      (rearm),
        .o_mem_addr   (addrSmall),
        .o_mem_data   (dataSmall),
        .o_mem_we     (weSmall),
        .o_busy       (busySmall),
        .o_load_done  (doneSmall),
        .o_overflow   (ovfSmall),
        .o_word_count (cntSmall)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (weMain) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL main write: got addr 0x%0h data 0x%0h, expected no write", addrMain, dataMain);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("main write addr", 64'(addrMain), 64'(e.addr));
                checkOutput("main write data", 64'(dataMain), 64'(e.data));
            end
        end
        if (smallActive && weSmall) begin
            if (expQSmall.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL small write: got addr 0x%0h data 0x%0h, expected no write", addrSmall, dataSmall);
            end else begin
                wr_t e;
                e = expQSmall.pop_front();
                checkOutput("small write addr", 64'(addrSmall), 64'(e.addr));
                checkOutput("small write data", 64'(dataSmall), 64'(e.data));
            end
        end
    end

    task automatic pushWord();
        expQ.push_back('{addr: expAddr, data: modelWord});
        expAddr++;
        if (smallWords < 2) begin
            expQSmall.push_back('{addr: smallAddr, data: modelWord});
            smallAddr++;
            smallWords++;
        end
        modelWord = 32'd0;
        modelLane = 0;
    endtask

    task automatic modelAdd(input logic [7:0] b);
        modelWord[8*modelLane +: 8] = b;
        modelLane++;
        if (modelLane == 4) pushWord();
    endtask

    task automatic modelFlush();
        if (modelLane != 0) pushWord();
    endtask

    task automatic resetDut();
        @(negedge clk);
        #2 rstN = 1'b0;
        validIn   = 1'b0;
        clearSign = 1'b0;
        rearm     = 1'b0;
        dataIn    = 8'h00;
        expQ.delete();
        expQSmall.delete();
        modelWord  = 32'd0;
        modelLane  = 0;
        expAddr    = 8'd0;
        smallAddr  = 8'd0;
        smallWords = 0;
        @(negedge clk);
        checkOutput("reset addr",  64'(addrMain), 64'd0);
        checkOutput("reset we",    64'(weMain),   64'd0);
        checkOutput("reset busy",  64'(busyMain), 64'd0);
        checkOutput("reset done",  64'(doneMain), 64'd0);
        checkOutput("reset ovf",   64'(ovfMain),  64'd0);
        checkOutput("reset count", 64'(cntMain),  64'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    // Present one UART byte as a long valid level, optionally raising the timeout with it.
    task automatic applyStimulus(input logic [7:0] b, input bit withClear);
        modelAdd(b);
        if (withClear) modelFlush();
        @(negedge clk);
        dataIn  = b;
        validIn = 1'b1;
        if (withClear) clearSign = 1'b1;
        repeat (HOLD) @(negedge clk);
        validIn = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic endImage(input bit clearAlreadyHigh);
        int n;
        if (!clearAlreadyHigh) begin
            modelFlush();
            @(negedge clk);
            clearSign = 1'b1;
        end
        n = 0;
        while (!doneMain && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("load done", 64'(doneMain), 64'd1);
        repeat (4) @(negedge clk);
        clearSign = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("busy after done", 64'(busyMain), 64'd0);
        checkOutput("pending writes", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN      = 1'b1;
        validIn   = 1'b0;
        clearSign = 1'b0;
        rearm     = 1'b0;
        dataIn    = 8'h00;

        vecs[0] = '{bytesLe: 64'h8877665544332211, nBytes: 4'd8, expCount: 9'd2};
        vecs[1] = '{bytesLe: 64'h0000060504030201, nBytes: 4'd6, expCount: 9'd2};
        vecs[2] = '{bytesLe: 64'h00000000EFBEADDE, nBytes: 4'd4, expCount: 9'd1};
        vecs[3] = '{bytesLe: 64'h000000000000005A, nBytes: 4'd1, expCount: 9'd1};

        for (int v = 0; v < 4; v++) begin
            logic [63:0] bl;
            resetDut();
            bl = vecs[v].bytesLe;
            for (int j = 0; j < int'(vecs[v].nBytes); j++) begin
                applyStimulus(bl[8*j +: 8], 1'b0);
            end
            endImage(1'b0);
            checkOutput("table word count", 64'(cntMain), 64'(vecs[v].expCount));
            checkOutput("table overflow",   64'(ovfMain), 64'd0);
        end

        // Timeout with no traffic must be ignored; a later byte still starts a load.
        resetDut();
        for (int k = 0; k < 3; k++) begin
            clearSign = 1'b1;
            repeat (10) @(negedge clk);
            clearSign = 1'b0;
            repeat (10) @(negedge clk);
        end
        checkOutput("idle clear done",  64'(doneMain), 64'd0);
        checkOutput("idle clear busy",  64'(busyMain), 64'd0);
        checkOutput("idle clear count", 64'(cntMain),  64'd0);
        applyStimulus(8'h77, 1'b0);
        checkOutput("busy after first byte", 64'(busyMain), 64'd1);
        endImage(1'b0);
        checkOutput("single byte count", 64'(cntMain), 64'd1);

        // Capacity of two words: the third word's bytes are dropped.
        resetDut();
        smallActive = 1'b1;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(8'h21 + 8'(k), 1'b0);
        end
        checkOutput("small overflow",       64'(ovfSmall),  64'd1);
        checkOutput("small count",          64'(cntSmall),  64'd2);
        checkOutput("small busy",           64'(busySmall), 64'd1);
        checkOutput("main no overflow",     64'(ovfMain),   64'd0);
        endImage(1'b0);
        checkOutput("small done",           64'(doneSmall), 64'd1);
        checkOutput("small pending writes", 64'(expQSmall.size()), 64'd0);
        checkOutput("main count 12 bytes",  64'(cntMain),   64'd3);
        smallActive = 1'b0;

        // Fourth byte and timeout in the same cycle: one write, no flush.
        resetDut();
        applyStimulus(8'h31, 1'b0);
        applyStimulus(8'h32, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h34, 1'b1);
        endImage(1'b1);
        checkOutput("same-cycle full count", 64'(cntMain), 64'd1);

        // Second byte of a word and timeout together: flush carries that byte.
        resetDut();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(8'h41 + 8'(k), 1'b0);
        end
        applyStimulus(8'h46, 1'b1);
        endImage(1'b1);
        checkOutput("same-cycle partial count", 64'(cntMain), 64'd2);

        // Reset in the middle of a word abandons it, then a fresh image loads at base.
        resetDut();
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h03, 1'b0);
        resetDut();
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hBB, 1'b0);
        applyStimulus(8'hCC, 1'b0);
        applyStimulus(8'hDD, 1'b0);
        endImage(1'b0);
        checkOutput("after reset count", 64'(cntMain), 64'd1);

        @(negedge clk);
        rearm = 1'b1;
        @(negedge clk);
        rearm = 1'b0;
        expAddr = 8'd0;
        checkOutput("rearm done",  64'(doneMain), 64'd0);
        checkOutput("rearm count", 64'(cntMain),  64'd0);
        checkOutput("rearm addr",  64'(addrMain), 64'd0);
        checkOutput("rearm busy",  64'(busyMain), 64'd0);

        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h11, 1'b0);
        @(negedge clk);
        rearm = 1'b1;
        @(negedge clk);
        rearm = 1'b0;
        @(negedge clk);
        checkOutput("rearm ignored busy", 64'(busyMain), 64'd1);
        checkOutput("rearm ignored done", 64'(doneMain), 64'd0);
        applyStimulus(8'h12, 1'b0);
        applyStimulus(8'h13, 1'b0);
        applyStimulus(8'h14, 1'b0);
        endImage(1'b0);
        checkOutput("reload count", 64'(cntMain), 64'd2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
